// File: rtl/packetmem_write_adapter.sv
// Packet-memory write adapter: turns big-endian byte/half/word writes at any byte
// address into one or two aligned 32-bit word beats. Optional macro WRITE_ADAPTER_ERR_EN.
module packetmem_write_adapter #(
  parameter  int PACKET_BYTE_ADDR_WIDTH = 12,
  localparam int WORD_ADDR_WIDTH        = PACKET_BYTE_ADDR_WIDTH - 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [PACKET_BYTE_ADDR_WIDTH-1:0] byte_wr_addr,
  input  logic [1:0]                        transfer_sz,
  input  logic [31:0]                       wr_data,
  input  logic                              in_valid,
  output logic                              in_ready,
  output logic                              mem_wr_en,
  input  logic                              mem_wr_ready,
  output logic [WORD_ADDR_WIDTH-1:0]        mem_word_addr,
  output logic [3:0]                        mem_be,
  output logic [31:0]                       mem_wr_data
`ifdef WRITE_ADAPTER_ERR_EN
  ,
  output logic                              err_illegal_sz
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_LAST, S_FIRST} state_e;

  state_e                     state_q, state_d;
  logic [WORD_ADDR_WIDTH-1:0] addr_q, addr_d, addr2_q, addr2_d;
  logic [3:0]                 be_q, be_d, be2_q, be2_d;
  logic [31:0]                data_q, data_d, data2_q, data2_d;
  logic                       err_q, err_d;

  logic [1:0]                 off;
  logic [2:0]                 nbytes;
  logic [3:0]                 nmask;
  logic [31:0]                dmask;
  logic [3:0]                 shamt;
  logic [63:0]                wide;
  logic [7:0]                 be8;
  logic                       split, accept, illegal;
  logic [WORD_ADDR_WIDTH-1:0] word_a, word_b;

  assign off = byte_wr_addr[1:0];

  always_comb begin
    nbytes = 3'd1;
    nmask  = 4'b0001;
    dmask  = 32'h0000_00ff;
    case (transfer_sz)
      2'b00: begin nbytes = 3'd4; nmask = 4'b1111; dmask = 32'hffff_ffff; end
      2'b01: begin nbytes = 3'd2; nmask = 4'b0011; dmask = 32'h0000_ffff; end
      default: ;
    endcase
  end

  // Place the value in an 8-byte big-endian window starting at word A; the upper
  // half is beat 1, the lower half (if any lanes are enabled) is beat 2.
  assign shamt  = 4'd8 - {2'b00, off} - {1'b0, nbytes};
  assign wide   = {32'b0, wr_data & dmask} << {shamt, 3'b000};
  assign be8    = {4'b0000, nmask} << shamt;
  assign split  = |be8[3:0];
  assign word_a = byte_wr_addr[PACKET_BYTE_ADDR_WIDTH-1:2];
  assign word_b = word_a + {{(WORD_ADDR_WIDTH-1){1'b0}}, 1'b1};
  assign accept = in_valid && in_ready;

`ifdef WRITE_ADAPTER_ERR_EN
  assign illegal = (transfer_sz == 2'b11);
`else
  assign illegal = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    be_d     = be_q;
    data_d   = data_q;
    addr2_d  = addr2_q;
    be2_d    = be2_q;
    data2_d  = data2_q;
    in_ready = 1'b0;
    case (state_q)
      S_IDLE: in_ready = 1'b1;
      S_FIRST: begin
        if (mem_wr_ready) begin
          state_d = S_LAST;
          addr_d  = addr2_q;
          be_d    = be2_q;
          data_d  = data2_q;
        end
      end
      S_LAST: begin
        in_ready = mem_wr_ready;
        if (mem_wr_ready) begin
          state_d = S_IDLE;
          addr_d  = '0;
          be_d    = '0;
          data_d  = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // A new request can only be accepted once the held beat is gone, so it overrides.
    if (accept && !illegal) begin
      state_d = split ? S_FIRST : S_LAST;
      addr_d  = word_a;
      be_d    = be8[7:4];
      data_d  = wide[63:32];
      addr2_d = word_b;
      be2_d   = be8[3:0];
      data2_d = wide[31:0];
    end
    err_d = err_q | (accept & illegal);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      be_q    <= '0;
      data_q  <= '0;
      addr2_q <= '0;
      be2_q   <= '0;
      data2_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      data_q  <= data_d;
      addr2_q <= addr2_d;
      be2_q   <= be2_d;
      data2_q <= data2_d;
      err_q   <= err_d;
    end
  end

  assign mem_wr_en     = (state_q != S_IDLE);
  assign mem_word_addr = addr_q;
  assign mem_be        = be_q;
  assign mem_wr_data   = data_q;

`ifdef WRITE_ADAPTER_ERR_EN
  assign err_illegal_sz = err_q;
`else
  logic unused_err;
  assign unused_err = err_q;
`endif

endmodule

// File: tb/tb_packetmem_write_adapter.sv
// Self-checking bench for packetmem_write_adapter: directed vector table, stall/reset
// sequence, and randomized traffic scored against a byte-level reference model.
module tb_packetmem_write_adapter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] byte_wr_addr = '0;
  logic [1:0]  transfer_sz = '0;
  logic [31:0] wr_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        mem_wr_en;
  logic        mem_wr_ready = 1'b1;
  logic [9:0]  mem_word_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wr_data;
`ifdef WRITE_ADAPTER_ERR_EN
  logic        err_illegal_sz;
`endif

  packetmem_write_adapter #(.PACKET_BYTE_ADDR_WIDTH(12)) dut (
    .clk(clk), .rst(rst), .byte_wr_addr(byte_wr_addr), .transfer_sz(transfer_sz),
    .wr_data(wr_data), .in_valid(in_valid), .in_ready(in_ready), .mem_wr_en(mem_wr_en),
    .mem_wr_ready(mem_wr_ready), .mem_word_addr(mem_word_addr), .mem_be(mem_be),
    .mem_wr_data(mem_wr_data)
`ifdef WRITE_ADAPTER_ERR_EN
    , .err_illegal_sz(err_illegal_sz)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic mon_en = 1'b0;

  typedef struct {
    logic [9:0]  a;
    logic [3:0]  be;
    logic [31:0] d;
  } beat_t;

  typedef struct {
    logic [11:0] a;  logic [1:0] sz; logic [31:0] d; int nb;
    logic [9:0]  a1; logic [3:0] be1; logic [31:0] d1;
    logic [9:0]  a2; logic [3:0] be2; logic [31:0] d2;
  } vec_t;

  beat_t expq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: walk the written bytes one at a time, grouping consecutive ones by word.
  task automatic model_push(input logic [11:0] addr, input logic [1:0] sz, input logic [31:0] data);
    int n, ba, w, lane, cur;
    beat_t b;
`ifdef WRITE_ADAPTER_ERR_EN
    if (sz == 2'b11) return;
`endif
    n = (sz == 2'b00) ? 4 : (sz == 2'b01) ? 2 : 1;
    cur = -1;
    b = '{a: '0, be: '0, d: '0};
    for (int i = 0; i < n; i++) begin
      ba   = (int'(addr) + i) % 4096;
      w    = ba / 4;
      lane = ba % 4;
      if (w != cur) begin
        if (cur >= 0) expq.push_back(b);
        b = '{a: 10'(w), be: '0, d: '0};
        cur = w;
      end
      b.be[3-lane] = 1'b1;
      b.d[31-8*lane -: 8] = 8'((data >> (8*(n-1-i))) & 32'hff);
    end
    expq.push_back(b);
  endtask

  // Scoreboard / protocol monitor for the randomized phases.
  initial begin
    beat_t held, e;
    logic  stalled = 1'b0;
    forever begin
      @(negedge clk);
      if (mon_en && !rst) begin
        chk("mon_wr_en", 32'(mem_wr_en), 32'(expq.size() != 0));
        chk("mon_in_ready", 32'(in_ready),
            32'(expq.size() == 0 || (expq.size() == 1 && mem_wr_ready)));
        if (stalled) begin
          chk("mon_hold_addr", 32'(mem_word_addr), 32'(held.a));
          chk("mon_hold_be", 32'(mem_be), 32'(held.be));
          chk("mon_hold_data", mem_wr_data, held.d);
        end
        if (mem_wr_en && mem_wr_ready && expq.size() > 0) begin
          e = expq.pop_front();
          chk("mon_addr", 32'(mem_word_addr), 32'(e.a));
          chk("mon_be", 32'(mem_be), 32'(e.be));
          chk("mon_data", mem_wr_data, e.d);
        end
        stalled = mem_wr_en && !mem_wr_ready;
        held = '{a: mem_word_addr, be: mem_be, d: mem_wr_data};
        if (in_valid && in_ready) model_push(byte_wr_addr, transfer_sz, wr_data);
      end else begin
        stalled = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: timeout, errors %0d", errors);
    $fatal(1, "timeout");
  end

  vec_t vecs[9];

  task automatic chk_beat(input string name, input logic [9:0] a, input logic [3:0] be,
                          input logic [31:0] d);
    chk({name, "_en"}, 32'(mem_wr_en), 32'd1);
    chk({name, "_addr"}, 32'(mem_word_addr), 32'(a));
    chk({name, "_be"}, 32'(mem_be), 32'(be));
    chk({name, "_data"}, mem_wr_data, d);
  endtask

  initial begin
    vecs[0] = '{12'h001, 2'b00, 32'hDEADBEEF, 2, 10'h000, 4'b0111, 32'h00DEADBE, 10'h001, 4'b1000, 32'hEF000000};
    vecs[1] = '{12'h006, 2'b01, 32'h0000ABCD, 1, 10'h001, 4'b0011, 32'h0000ABCD, 10'h000, 4'b0000, 32'h0};
    vecs[2] = '{12'h003, 2'b01, 32'h00001234, 2, 10'h000, 4'b0001, 32'h00000012, 10'h001, 4'b1000, 32'h34000000};
    vecs[3] = '{12'h00E, 2'b10, 32'h0000005A, 1, 10'h003, 4'b0010, 32'h00005A00, 10'h000, 4'b0000, 32'h0};
    vecs[4] = '{12'hFFE, 2'b00, 32'h11223344, 2, 10'h3FF, 4'b0011, 32'h00001122, 10'h000, 4'b1100, 32'h33440000};
    vecs[5] = '{12'h100, 2'b00, 32'hCAFEF00D, 1, 10'h040, 4'b1111, 32'hCAFEF00D, 10'h000, 4'b0000, 32'h0};
    vecs[6] = '{12'h7FF, 2'b10, 32'hFFFFFF99, 1, 10'h1FF, 4'b0001, 32'h00000099, 10'h000, 4'b0000, 32'h0};
    vecs[7] = '{12'h7FD, 2'b01, 32'hFFFF5566, 1, 10'h1FF, 4'b0110, 32'h00556600, 10'h000, 4'b0000, 32'h0};
    vecs[8] = '{12'h003, 2'b00, 32'hA1B2C3D4, 2, 10'h000, 4'b0001, 32'h000000A1, 10'h001, 4'b1110, 32'hB2C3D400};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    chk("rst_wr_en", 32'(mem_wr_en), 32'd0);
    chk("rst_be", 32'(mem_be), 32'd0);
    chk("rst_data", mem_wr_data, 32'd0);
    chk("rst_addr", 32'(mem_word_addr), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
`ifdef WRITE_ADAPTER_ERR_EN
    chk("rst_err", 32'(err_illegal_sz), 32'd0);
`endif

    // Directed vector table
    foreach (vecs[i]) begin
      @(posedge clk); #1;
      byte_wr_addr = vecs[i].a; transfer_sz = vecs[i].sz; wr_data = vecs[i].d;
      in_valid = 1'b1; mem_wr_ready = 1'b1;
      @(negedge clk);
      chk("vec_accept_ready", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      chk_beat("vec_beat1", vecs[i].a1, vecs[i].be1, vecs[i].d1);
      chk("vec_ready_b1", 32'(in_ready), 32'(vecs[i].nb == 1));
      if (vecs[i].nb == 2) begin
        @(negedge clk);
        chk_beat("vec_beat2", vecs[i].a2, vecs[i].be2, vecs[i].d2);
        chk("vec_ready_b2", 32'(in_ready), 32'd1);
      end
      @(negedge clk);
      chk("vec_idle", 32'(mem_wr_en), 32'd0);
    end

    // Back-to-back aligned word writes under the monitor
    mon_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      byte_wr_addr = 12'(16 * i); transfer_sz = 2'b00; wr_data = $urandom; in_valid = 1'b1;
      @(negedge clk);
      chk("b2b_in_ready", 32'(in_ready), 32'd1);
    end
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    mon_en = 1'b0;

    // Split write with beat 1 stalled, then reset while beat 2 is held
    @(posedge clk); #1;
    byte_wr_addr = 12'h001; transfer_sz = 2'b00; wr_data = 32'hDEADBEEF;
    in_valid = 1'b1; mem_wr_ready = 1'b0;
    @(posedge clk); #1 in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_beat("stall_beat1", 10'h000, 4'b0111, 32'h00DEADBE);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
    end
    #1 mem_wr_ready = 1'b1;
    @(posedge clk); #1 mem_wr_ready = 1'b0;
    @(negedge clk);
    chk_beat("stall_beat2", 10'h001, 4'b1000, 32'hEF000000);
    #1 rst = 1'b1;
    #1;
    chk("midrst_wr_en", 32'(mem_wr_en), 32'd0);
    chk("midrst_be", 32'(mem_be), 32'd0);
    chk("midrst_data", mem_wr_data, 32'd0);
    chk("midrst_addr", 32'(mem_word_addr), 32'd0);
    @(negedge clk) rst = 1'b0; mem_wr_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("postrst_wr_en", 32'(mem_wr_en), 32'd0);
      chk("postrst_in_ready", 32'(in_ready), 32'd1);
    end

`ifdef WRITE_ADAPTER_ERR_EN
    // Illegal size: no beat, sticky error until reset
    @(posedge clk); #1;
    byte_wr_addr = 12'h010; transfer_sz = 2'b11; wr_data = 32'h77; in_valid = 1'b1;
    @(negedge clk);
    chk("err_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1 in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("err_no_beat", 32'(mem_wr_en), 32'd0);
      chk("err_set", 32'(err_illegal_sz), 32'd1);
    end
    @(negedge clk) rst = 1'b1;
    #1 chk("err_cleared", 32'(err_illegal_sz), 32'd0);
    @(negedge clk) rst = 1'b0;
`endif

    // Randomized traffic with random backpressure
    mon_en = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk); #1;
      mem_wr_ready = ($urandom_range(0, 3) != 0);
      in_valid     = ($urandom_range(0, 2) != 0);
      byte_wr_addr = ($urandom_range(0, 3) == 0) ? 12'(4092 + $urandom_range(0, 3))
                                                 : 12'($urandom_range(0, 4095));
`ifdef WRITE_ADAPTER_ERR_EN
      transfer_sz  = 2'($urandom_range(0, 2));
`else
      transfer_sz  = 2'($urandom_range(0, 3));
`endif
      wr_data      = $urandom;
    end
    @(posedge clk); #1 in_valid = 1'b0; mem_wr_ready = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("drain_queue_empty", 32'(expq.size()), 32'd0);
    mon_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
